// File: rtl/adc_resp_emulator_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_resp_emulator_if
// Description : Avalon-ST command/response bundle between a conversion
//               requester (master) and the ADC response emulator (slave).
//               Command side : command_valid/channel/SOP/EOP in, ready out.
//               Response side: single-cycle valid beat with channel, 12-bit
//                              data and SOP/EOP; no backpressure.
// Revision    : 1.0  initial release
// ============================================================================
interface adc_resp_emulator_if;
  logic       command_valid;
  logic [4:0] command_channel;
  logic       command_startofpacket;
  logic       command_endofpacket;
  logic       command_ready;
  logic       response_valid;
  logic [4:0] response_channel;
  logic [11:0] response_data;
  logic       response_startofpacket;
  logic       response_endofpacket;

  modport master (
    output command_valid, command_channel, command_startofpacket, command_endofpacket,
    input  command_ready,
    input  response_valid, response_channel, response_data,
           response_startofpacket, response_endofpacket
  );

  modport slave (
    input  command_valid, command_channel, command_startofpacket, command_endofpacket,
    output command_ready,
    output response_valid, response_channel, response_data,
           response_startofpacket, response_endofpacket
  );
endinterface
`default_nettype wire

// File: rtl/adc_resp_emulator.sv
`default_nettype none
// ============================================================================
// Module      : adc_resp_emulator
// Description : Stand-in for the MAX10 modular ADC command/response path.
//               Accepts one conversion command at a time, waits CONV_CYCLES,
//               then emits one response beat. The temperature channel
//               returns a wrapping ramp; other valid channels return
//               {channel, 7'b0}; out-of-range channels return 0.
// Ports       : clock  - system clock
//               reset  - asynchronous, active-high reset
//               bus    - adc_resp_emulator_if.slave (command + response)
// Options     : ADC_EMU_NOISE_EN - adds LFSR[1:0] dither (saturating) to
//               temperature samples; the ramp itself is unaffected.
// Revision    : 1.0  initial release
// ============================================================================
module adc_resp_emulator #(
  parameter int          CONV_CYCLES = 50,
  parameter logic [4:0]  TEMP_CH     = 5'd17,
  parameter logic [11:0] TEMP_BASE   = 12'd3431,
  parameter logic [11:0] TEMP_MAX    = 12'd3481,
  parameter logic [4:0]  MAX_CH      = 5'd17
) (
  input  wire logic           clock,
  input  wire logic           reset,
  adc_resp_emulator_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  localparam logic [9:0] c_CNT_LOAD = 10'(CONV_CYCLES - 1);

  logic [1:0]  r_state;
  logic [9:0]  r_cnt;
  logic [4:0]  r_ch;
  logic        r_sop;
  logic        r_eop;
  logic [11:0] r_ramp;
  logic        r_ready;
  logic        r_resp_valid;
  logic [4:0]  r_resp_ch;
  logic [11:0] r_resp_data;
  logic        r_resp_sop;
  logic        r_resp_eop;

  logic [11:0] w_temp_data;
  logic [11:0] w_resp_data;
  logic [11:0] w_ramp_next;

`ifdef ADC_EMU_NOISE_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;
  logic [12:0] w_temp_sum;

  // Fibonacci form, taps 16,14,13,11 (bits 15,13,12,10)
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  assign w_temp_sum  = {1'b0, r_ramp} + {11'd0, r_lfsr[1:0]};
  assign w_temp_data = w_temp_sum[12] ? 12'hFFF : w_temp_sum[11:0];
`else
  assign w_temp_data = r_ramp;
`endif

  assign w_ramp_next = (r_ramp == TEMP_MAX) ? TEMP_BASE : (r_ramp + 12'd1);

  always_comb begin
    w_resp_data = 12'h000;
    if (r_ch == TEMP_CH) begin
      w_resp_data = w_temp_data;
    end else if (r_ch <= MAX_CH) begin
      w_resp_data = {r_ch, 7'b0};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 10'd0;
      r_ch         <= 5'd0;
      r_sop        <= 1'b0;
      r_eop        <= 1'b0;
      r_ramp       <= TEMP_BASE;
      r_ready      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_ch    <= 5'd0;
      r_resp_data  <= 12'h000;
      r_resp_sop   <= 1'b0;
      r_resp_eop   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_ready && bus.command_valid) begin
            r_ch    <= bus.command_channel;
            r_sop   <= bus.command_startofpacket;
            r_eop   <= bus.command_endofpacket;
            r_cnt   <= c_CNT_LOAD;
            r_ready <= 1'b0;
            r_state <= S_CONVERT;
          end else begin
            // First edge after reset release raises ready
            r_ready <= 1'b1;
          end
        end
        S_CONVERT: begin
          if (r_cnt == 10'd0) begin
            // Response registers load here so the beat is visible
            // throughout the RESPOND cycle.
            r_state      <= S_RESPOND;
            r_resp_valid <= 1'b1;
            r_resp_ch    <= r_ch;
            r_resp_data  <= w_resp_data;
            r_resp_sop   <= r_sop;
            r_resp_eop   <= r_eop;
            if (r_ch == TEMP_CH) begin
              r_ramp <= w_ramp_next;
            end
          end else begin
            r_cnt <= r_cnt - 10'd1;
          end
        end
        S_RESPOND: begin
          r_resp_valid <= 1'b0;
          r_ready      <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.command_ready          = r_ready;
  assign bus.response_valid         = r_resp_valid;
  assign bus.response_channel       = r_resp_ch;
  assign bus.response_data          = r_resp_data;
  assign bus.response_startofpacket = r_resp_sop;
  assign bus.response_endofpacket   = r_resp_eop;

endmodule
`default_nettype wire

// File: tb/tb_adc_resp_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_resp_emulator
// Description : Self-checking bench for adc_resp_emulator. A timestamp-based
//               reference model predicts every output each cycle; directed
//               scenarios pin latency, ramp wrap, channel data rules and
//               reset abort, followed by randomized command traffic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_adc_resp_emulator;

  localparam int CONV = 50;
  localparam int TCH  = 17;
  localparam int TBASE = 3431;
  localparam int TMAX  = 3481;
  localparam int MAXCH = 17;

  logic clock = 1'b0;
  logic reset = 1'b1;

  adc_resp_emulator_if bus ();

  adc_resp_emulator #(
    .CONV_CYCLES (CONV),
    .TEMP_CH     (5'd17),
    .TEMP_BASE   (12'd3431),
    .TEMP_MAX    (12'd3481),
    .MAX_CH      (5'd17)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Beats observed on the DUT
  int bq_data[$];
  int bq_ch[$];
  int bq_cyc[$];
  int bq_se[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Literal temperature expectation; with dither the value may sit up to +3
  task automatic chk_temp(input string name, input int act, input int ramp);
`ifdef ADC_EMU_NOISE_EN
    total++;
    if (act < ramp || act > ramp + 3) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, ramp, ramp + 3);
    end
`else
    chk(name, act, ramp);
`endif
  endtask

  // ---------------------------------------------------------------------
  // Reference model + per-cycle comparison
  // ---------------------------------------------------------------------
  initial begin : model
    logic r_in, v_in, s_in, e_in;
    int   ch_in;
    bit   m_ready, m_valid, m_pending, m_sop, m_eop, p_sop, p_eop;
    int   m_ch, m_data, m_ramp, m_due, p_ch;
    int   lfsr;
    int   d;
    m_ready = 0; m_valid = 0; m_pending = 0; m_sop = 0; m_eop = 0;
    p_sop = 0; p_eop = 0; m_ch = 0; m_data = 0; m_ramp = TBASE;
    m_due = 0; p_ch = 0; lfsr = 16'hACE1;
    forever begin
      @(posedge clock);
      r_in  = reset;
      v_in  = bus.command_valid;
      ch_in = int'(bus.command_channel);
      s_in  = bus.command_startofpacket;
      e_in  = bus.command_endofpacket;
      #1;
      if (r_in) begin
        m_ready = 0; m_valid = 0; m_pending = 0;
        m_ch = 0; m_data = 0; m_sop = 0; m_eop = 0;
        m_ramp = TBASE; lfsr = 16'hACE1;
      end else begin
        if (m_valid) begin
          m_valid = 0;
          m_ready = 1;
        end else if (m_pending && cyc == m_due) begin
          m_pending = 0;
          m_valid = 1;
          m_ch = p_ch; m_sop = p_sop; m_eop = p_eop;
          if (p_ch == TCH) begin
            d = m_ramp;
`ifdef ADC_EMU_NOISE_EN
            d = d + (lfsr % 4);
            if (d > 4095) d = 4095;
`endif
            m_data = d;
            m_ramp = (m_ramp == TMAX) ? TBASE : m_ramp + 1;
          end else if (p_ch <= MAXCH) begin
            m_data = p_ch * 128;
          end else begin
            m_data = 0;
          end
        end else if (m_ready && v_in) begin
          m_ready = 0;
          m_pending = 1;
          m_due = cyc + CONV;
          p_ch = ch_in; p_sop = s_in; p_eop = e_in;
        end else if (!m_pending && !m_ready) begin
          m_ready = 1;
        end
        // 16-bit Fibonacci LFSR, taps 16,14,13,11
        lfsr = ((lfsr << 1) & 16'hFFFF) |
               (((lfsr >> 15) ^ (lfsr >> 13) ^ (lfsr >> 12) ^ (lfsr >> 10)) & 1);
      end
      total++;
      if ({bus.command_ready, bus.response_valid, bus.response_channel,
           bus.response_data, bus.response_startofpacket, bus.response_endofpacket} !==
          {m_ready, m_valid, 5'(m_ch), 12'(m_data), m_sop, m_eop}) begin
        bad++;
        $display("FAIL cycle%0d: got rdy=%0b vld=%0b ch=%0d data=%0d sop=%0b eop=%0b expected rdy=%0b vld=%0b ch=%0d data=%0d sop=%0b eop=%0b",
                 cyc, bus.command_ready, bus.response_valid, bus.response_channel,
                 bus.response_data, bus.response_startofpacket, bus.response_endofpacket,
                 m_ready, m_valid, m_ch, m_data, m_sop, m_eop);
      end
      if (bus.response_valid === 1'b1) begin
        bq_data.push_back(int'(bus.response_data));
        bq_ch.push_back(int'(bus.response_channel));
        bq_cyc.push_back(cyc);
        bq_se.push_back(int'({bus.response_startofpacket, bus.response_endofpacket}));
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic send(input int ch, input bit s, input bit e, output int acc);
    bus.command_valid         = 1'b1;
    bus.command_channel       = 5'(ch);
    bus.command_startofpacket = s;
    bus.command_endofpacket   = e;
    acc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (bus.command_ready === 1'b1) begin
        @(posedge clock);
        #1;
        acc = cyc;
        break;
      end
    end
    if (acc < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_beats(input int target);
    for (int i = 0; i < 3000 && bq_data.size() < target; i++) begin
      @(posedge clock);
      #2;
    end
    chk("beat_count", bq_data.size(), target);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.command_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc;
    int n0;
    int accs[52];
    bus.command_valid = 1'b0;
    bus.command_channel = 5'd0;
    bus.command_startofpacket = 1'b0;
    bus.command_endofpacket = 1'b0;

    // 1. Reset release and first temperature conversion
    repeat (3) @(negedge clock);
    chk("ready_in_reset", int'(bus.command_ready), 0);
    chk("data_in_reset", int'(bus.response_data), 0);
    reset = 1'b0;
    bus.command_valid = 1'b1;
    bus.command_channel = 5'd17;
    bus.command_startofpacket = 1'b1;
    bus.command_endofpacket = 1'b1;
    @(posedge clock);
    #2;
    chk("ready_after_release", int'(bus.command_ready), 1);
    send(17, 1, 1, acc);
    bus.command_valid = 1'b0;
    wait_beats(1);
    chk("t1_latency", bq_cyc[0] - acc, CONV);
    chk_temp("t1_data", bq_data[0], 3431);
    chk("t1_channel", bq_ch[0], 17);
    chk("t1_sopeop", bq_se[0], 3);
    @(posedge clock);
    #2;
    chk("t1_ready_back", int'(bus.command_ready), 1);
    repeat (10) @(posedge clock);
    #2;
    chk("t1_single_beat", bq_data.size(), 1);

    // 2. 52 back-to-back temperature commands: full ramp plus wrap
    do_reset();
    n0 = bq_data.size();
    for (int k = 0; k < 52; k++) begin
      send(17, 1, 1, accs[k]);
    end
    bus.command_valid = 1'b0;
    wait_beats(n0 + 52);
    chk_temp("t2_first", bq_data[n0], 3431);
    chk_temp("t2_last_before_wrap", bq_data[n0 + 50], 3481);
    chk_temp("t2_wrapped", bq_data[n0 + 51], 3431);
    for (int k = 1; k < 52; k++) begin
      chk("t2_spacing", accs[k] - accs[k-1], CONV + 2);
    end

    // 3. Channel 3, then temperature continues the ramp
    n0 = bq_data.size();
    send(3, 1, 0, acc);
    bus.command_valid = 1'b0;
    wait_beats(n0 + 1);
    chk("t3_data", bq_data[n0], 12'h180);
    chk("t3_channel", bq_ch[n0], 3);
    chk("t3_sopeop", bq_se[n0], 2);
    send(17, 0, 1, acc);
    bus.command_valid = 1'b0;
    wait_beats(n0 + 2);
    chk_temp("t3_ramp_continues", bq_data[n0 + 1], 3432);

    // 4. Out-of-range channel
    n0 = bq_data.size();
    send(25, 0, 0, acc);
    bus.command_valid = 1'b0;
    wait_beats(n0 + 1);
    chk("t4_data", bq_data[n0], 0);
    chk("t4_channel", bq_ch[n0], 25);

    // 5. Reset 20 cycles into a conversion
    send(17, 1, 1, acc);
    bus.command_valid = 1'b0;
    n0 = bq_data.size();
    repeat (20) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("t5_ready_cleared", int'(bus.command_ready), 0);
    chk("t5_channel_cleared", int'(bus.response_channel), 0);
    chk("t5_data_cleared", int'(bus.response_data), 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (60) @(negedge clock);
    chk("t5_no_beat", bq_data.size(), n0);
    send(17, 1, 1, acc);
    bus.command_valid = 1'b0;
    wait_beats(n0 + 1);
    chk_temp("t5_ramp_reset", bq_data[n0], 3431);

    // Randomized traffic against the model
    for (int k = 0; k < 40; k++) begin
      int ch;
      ch = ($urandom_range(0, 2) == 0) ? 17 : int'($urandom_range(0, 31));
      send(ch, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
      if ($urandom_range(0, 1) == 0) bus.command_valid = 1'b0;
      repeat ($urandom_range(0, 5)) @(negedge clock);
    end
    bus.command_valid = 1'b0;
    repeat (CONV + 10) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
